// File: rtl/apb_sleep_master.sv
// Single-outstanding APB initiator: turns a req/gnt/rvalid port into APB
// SETUP/ACCESS phases with wait-state handling, PSLVERR reporting and a stall timeout.
module apb_sleep_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          grant, complete, abort;

  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  logic                      rvalid_q, err_q;
  logic [31:0]               rdata_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          grant      = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        // cnt holds the wait cycles already seen, so the abort lands on the
        // TIMEOUT_CYCLES-th stalled ACCESS cycle; a late PREADY still completes.
        if (PREADY) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
          if ((TIMEOUT_CYCLES != 0) && (cnt_next == TO_LIMIT)) begin
            abort      = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= complete | abort;
      if (complete) begin
        err_q   <= PSLVERR;
        rdata_q <= pwrite_q ? 32'h0 : PRDATA;
      end else if (abort) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end else begin
        err_q <= 1'b0;
      end
      if (grant) begin
        paddr_q  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
        pwrite_q <= we_i;
        pwdata_q <= we_i ? wdata_i : 32'h0;
      end
    end
  end

  assign gnt_o    = grant & HRESETn;
  assign PSEL     = (state != IDLE);
  assign PENABLE  = (state == ACCESS);
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_apb_sleep_master.sv
// Directed bench for apb_sleep_master: stimulus pushes expected responses to a
// scoreboard that a negedge monitor pops on every rvalid_o pulse.
module tb_apb_sleep_master;

  logic        HCLK, HRESETn;
  logic        req_i, we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    vectors = 0;
  int    fails   = 0;

  apb_sleep_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [11:0] addr,
                               input logic [31:0] wdata);
    req_i   = req;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic expectResp(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata;
    r.err   = err;
    sb.push_back(r);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge HCLK) begin
    if (HRESETn && rvalid_o) begin
      checkOutput("sb_has_entry", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        resp_t r;
        r = sb.pop_front();
        checkOutput("resp_rdata", rdata_o, r.rdata);
        checkOutput("resp_err", {31'b0, err_o}, {31'b0, r.err});
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    applyStimulus(1'b0, 1'b0, 12'h0, 32'h0);
    tick(); tick();
    checkOutput("rst_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("rst_penable", {31'b0, PENABLE}, 32'd0);
    checkOutput("rst_pwrite", {31'b0, PWRITE}, 32'd0);
    checkOutput("rst_gnt", {31'b0, gnt_o}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    checkOutput("rst_err", {31'b0, err_o}, 32'd0);
    checkOutput("rst_paddr", {20'b0, PADDR}, 32'd0);
    checkOutput("rst_pwdata", PWDATA, 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    HRESETn = 1'b1;

    // Write, zero wait states
    tick();
    applyStimulus(1'b1, 1'b1, 12'h000, 32'h1);
    #1 checkOutput("w0_gnt", {31'b0, gnt_o}, 32'd1);
    expectResp(32'h0, 1'b0);
    tick();
    #1 checkOutput("w0_gnt_setup", {31'b0, gnt_o}, 32'd0);
    checkOutput("w0_psel", {31'b0, PSEL}, 32'd1);
    checkOutput("w0_penable_setup", {31'b0, PENABLE}, 32'd0);
    checkOutput("w0_paddr", {20'b0, PADDR}, 32'h0);
    checkOutput("w0_pwdata", PWDATA, 32'h1);
    checkOutput("w0_pwrite", {31'b0, PWRITE}, 32'd1);
    tick();
    req_i = 1'b0;
    checkOutput("w0_penable_access", {31'b0, PENABLE}, 32'd1);
    tick();
    checkOutput("w0_rvalid", {31'b0, rvalid_o}, 32'd1);
    checkOutput("w0_psel_idle", {31'b0, PSEL}, 32'd0);
    tick();
    checkOutput("w0_rvalid_pulse", {31'b0, rvalid_o}, 32'd0);

    // Read with three wait states; inputs change after grant
    applyStimulus(1'b1, 1'b0, 12'h004, 32'hDEADBEEF);
    PREADY = 1'b0;
    #1 checkOutput("r1_gnt", {31'b0, gnt_o}, 32'd1);
    expectResp(32'h1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 12'hFFC, 32'h0);
    checkOutput("r1_penable_setup", {31'b0, PENABLE}, 32'd0);
    checkOutput("r1_pwrite", {31'b0, PWRITE}, 32'd0);
    checkOutput("r1_pwdata", PWDATA, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("r1_wait_penable", {31'b0, PENABLE}, 32'd1);
      checkOutput("r1_wait_paddr", {20'b0, PADDR}, 32'h004);
      checkOutput("r1_wait_rvalid", {31'b0, rvalid_o}, 32'd0);
    end
    tick();
    PREADY = 1'b1;
    PRDATA = 32'h00000001;
    checkOutput("r1_last_paddr", {20'b0, PADDR}, 32'h004);
    tick();
    PRDATA = 32'h0;
    checkOutput("r1_rvalid", {31'b0, rvalid_o}, 32'd1);

    // Slave error on write
    tick();
    applyStimulus(1'b1, 1'b1, 12'h008, 32'h55);
    PSLVERR = 1'b1;
    expectResp(32'h0, 1'b1);
    tick();
    req_i = 1'b0;
    checkOutput("se_paddr", {20'b0, PADDR}, 32'h008);
    tick();
    tick();
    PSLVERR = 1'b0;
    checkOutput("se_rvalid", {31'b0, rvalid_o}, 32'd1);
    tick();
    checkOutput("se_err_pulse", {31'b0, err_o}, 32'd0);

    // Timeout: PREADY never rises
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    PREADY = 1'b0;
    PRDATA = 32'h1234;
    expectResp(32'h0, 1'b1);
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to_access_psel", {31'b0, PSEL}, 32'd1);
    end
    tick();
    checkOutput("to_psel_drop", {31'b0, PSEL}, 32'd0);
    checkOutput("to_rvalid", {31'b0, rvalid_o}, 32'd1);

    // PREADY on the final allowed ACCESS cycle beats the timeout
    applyStimulus(1'b1, 1'b0, 12'h004, 32'h0);
    expectResp(32'hA5, 1'b0);
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    PREADY = 1'b1;
    PRDATA = 32'hA5;
    tick();
    PRDATA = 32'h0;
    checkOutput("te_rvalid", {31'b0, rvalid_o}, 32'd1);
    checkOutput("te_psel", {31'b0, PSEL}, 32'd0);

    // Back-to-back writes with req_i held; low address bits are dropped
    tick();
    applyStimulus(1'b1, 1'b1, 12'h00B, 32'h11);
    #1 checkOutput("bb_gnt0", {31'b0, gnt_o}, 32'd1);
    expectResp(32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 12'h010, 32'h22);
    #1 checkOutput("bb_gnt_busy", {31'b0, gnt_o}, 32'd0);
    checkOutput("bb_paddr0", {20'b0, PADDR}, 32'h008);
    checkOutput("bb_pwdata0", PWDATA, 32'h11);
    tick();
    checkOutput("bb_paddr0_access", {20'b0, PADDR}, 32'h008);
    tick();
    #1 checkOutput("bb_rvalid0", {31'b0, rvalid_o}, 32'd1);
    checkOutput("bb_gnt1", {31'b0, gnt_o}, 32'd1);
    checkOutput("bb_psel_gap", {31'b0, PSEL}, 32'd0);
    expectResp(32'h0, 1'b0);
    tick();
    req_i = 1'b0;
    checkOutput("bb_psel1", {31'b0, PSEL}, 32'd1);
    checkOutput("bb_paddr1", {20'b0, PADDR}, 32'h010);
    checkOutput("bb_pwdata1", PWDATA, 32'h22);
    tick();
    tick();
    checkOutput("bb_rvalid1", {31'b0, rvalid_o}, 32'd1);
    tick();
    checkOutput("bb_paddr_hold", {20'b0, PADDR}, 32'h010);
    checkOutput("bb_pwdata_hold", PWDATA, 32'h22);

    // Reset during ACCESS, even with PREADY high, yields no response
    applyStimulus(1'b1, 1'b1, 12'h004, 32'h3);
    PREADY = 1'b0;
    tick();
    req_i = 1'b0;
    tick();
    checkOutput("rm_penable", {31'b0, PENABLE}, 32'd1);
    HRESETn = 1'b0;
    PREADY  = 1'b1;
    tick();
    checkOutput("rm_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("rm_penable_off", {31'b0, PENABLE}, 32'd0);
    checkOutput("rm_rvalid", {31'b0, rvalid_o}, 32'd0);
    HRESETn = 1'b1;
    tick();
    checkOutput("rm_rvalid_after", {31'b0, rvalid_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 12'h000, 32'h0);
    PRDATA = 32'h3;
    #1 checkOutput("rm_gnt_after", {31'b0, gnt_o}, 32'd1);
    expectResp(32'h3, 1'b0);
    tick();
    req_i = 1'b0;
    tick();
    tick();
    checkOutput("rm_rvalid_new", {31'b0, rvalid_o}, 32'd1);
    tick();
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
